load_store_unit: RTL and testbench

Initiator-side memory access controller between the CPU execute stage and the word-organised data memory. Accepts one load or store request at a time from the core, converts byte addresses to word indices, and performs byte/halfword stores by read-modify-write. Returns aligned, sign- or zero-extended load data as a one-cycle response pulse. The memory port matches the data memory contract: combinational read on `mem_A`, write on the clock edge when `mem_WE` is high.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 38 +++
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and byte-lane constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

  localparam logic [31:0] LANE_BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] LANE_HALF_MASK = 32'h0000_FFFF;

  // Bit position of the addressed lane inside a little-endian word.
  function automatic logic [4:0] lane_shift(input logic [1:0] offset);
    return {offset, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane extraction/extension for loads and lane merge for stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  lsu_size_t   size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [31:0] shifted_s;
  logic [31:0] mask_s;

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = word >> lane_shift(offset);
    case (size)
      BYTE:    load_val = {{24{sgn & shifted_s[7]}}, shifted_s[7:0]};
      HALF:    load_val = {{16{sgn & shifted_s[15]}}, shifted_s[15:0]};
      WORD:    load_val = word;
      default: load_val = 32'h0000_0000;
    endcase
  end

  // Store path: replace only the addressed lane of the fetched word.
  always_comb begin
    case (size)
      BYTE:    mask_s = LANE_BYTE_MASK << lane_shift(offset);
      HALF:    mask_s = LANE_HALF_MASK << lane_shift(offset);
      default: mask_s = 32'hFFFF_FFFF;
    endcase
    store_word = (word & ~mask_s) | ((wdata << lane_shift(offset)) & mask_s);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, sub-word stores by read-modify-write.
// Optional range check on the word index enabled by LSU_BOUNDS_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int W     = 32,
  parameter int D     = 32,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [D-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         resp_valid,
  output logic [W-1:0] resp_rdata,
  output logic         resp_err,
  output logic [D-1:0] mem_A,
  output logic [W-1:0] mem_WD,
  output logic         mem_WE,
  input  logic [W-1:0] mem_RD
);

  lsu_state_t   state_r;
  logic [D-1:0] addr_r;
  lsu_size_t    size_r;
  logic         signed_r;
  logic         we_r;
  logic [W-1:0] wdata_r;
  logic         mem_we_r;
  logic [D-1:0] mem_a_r;
  logic [W-1:0] mem_wd_r;
  logic         resp_valid_r;
  logic         resp_err_r;
  logic [W-1:0] resp_rdata_r;

  lsu_size_t    req_size_s;
  logic [D-1:0] req_index_s;
  logic         align_err_s;
  logic         req_err_s;
  logic [W-1:0] load_val_s;
  logic [W-1:0] store_word_s;

  assign req_ready   = (state_r == IDLE) && !rst;
  assign req_size_s  = lsu_size_t'(req_size);
  assign req_index_s = {2'b00, req_addr[D-1:2]};

  // Size and alignment legality of the incoming request.
  always_comb begin
    case (req_size_s)
      BYTE:    align_err_s = 1'b0;
      HALF:    align_err_s = req_addr[0];
      WORD:    align_err_s = (req_addr[1:0] != 2'b00);
      default: align_err_s = 1'b1;
    endcase
  end

`ifdef LSU_BOUNDS_CHECK_EN
  assign req_err_s = align_err_s | (req_index_s >= D'(DEPTH));
`else
  assign req_err_s = align_err_s;
`endif

  lsu_lane_align u_align (
    .word       (mem_RD),
    .offset     (addr_r[1:0]),
    .size       (size_r),
    .sgn        (signed_r),
    .wdata      (wdata_r),
    .load_val   (load_val_s),
    .store_word (store_word_s)
  );

  // Reset gates the write strobe so an interrupted RMW never commits.
  assign mem_WE     = mem_we_r & ~rst;
  assign mem_A      = mem_a_r;
  assign mem_WD     = mem_wd_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

  // Request sequencing with registered memory and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= {D{1'b0}};
      size_r       <= BYTE;
      signed_r     <= 1'b0;
      we_r         <= 1'b0;
      wdata_r      <= {W{1'b0}};
      mem_we_r     <= 1'b0;
      mem_a_r      <= {D{1'b0}};
      mem_wd_r     <= {W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= {W{1'b0}};
          mem_we_r     <= 1'b0;
          mem_a_r      <= {D{1'b0}};
          mem_wd_r     <= {W{1'b0}};
          if (req_valid) begin
            addr_r   <= req_addr;
            size_r   <= req_size_s;
            signed_r <= req_signed;
            we_r     <= req_we;
            wdata_r  <= req_wdata;
            if (req_err_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else if (req_we && (req_size_s == WORD)) begin
              state_r  <= WRITE;
              mem_a_r  <= req_index_s;
              mem_wd_r <= req_wdata;
              mem_we_r <= 1'b1;
            end else begin
              state_r <= READ;
              mem_a_r <= req_index_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if (we_r) begin
            state_r  <= WRITE;
            mem_wd_r <= store_word_s;
            mem_we_r <= 1'b1;
          end else begin
            state_r      <= RESP;
            mem_a_r      <= {D{1'b0}};
            resp_valid_r <= 1'b1;
            resp_rdata_r <= load_val_s;
          end
        end
        WRITE: begin
          state_r      <= RESP;
          mem_we_r     <= 1'b0;
          mem_a_r      <= {D{1'b0}};
          mem_wd_r     <= {W{1'b0}};
          resp_valid_r <= 1'b1;
        end
        RESP: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= {W{1'b0}};
        end
        default: begin
          state_r      <= IDLE;
          mem_we_r     <= 1'b0;
          mem_a_r      <= {D{1'b0}};
          mem_wd_r     <= {W{1'b0}};
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= {W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with response scoreboard
// plus directed sequences for reset during RMW, bounds and back-to-back stores.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  logic [31:0] mem [32];
  int total = 0;
  int bad   = 0;
  int we_count   = 0;
  int acc_count  = 0;
  int resp_count = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    logic        chk;
    int          chk_idx;
    logic [31:0] chk_val;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_RD     (mem_RD)
  );

  always #5 clk = ~clk;

  // Word-organised data memory, initialised to word i = i.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
    end else if (mem_WE && (mem_A < 32'd32)) begin
      mem[mem_A[4:0]] <= mem_WD;
    end
  end

  assign mem_RD = (mem_A < 32'd32) ? mem[mem_A[4:0]] : 32'h0;

  // Event counters for write strobes, acceptances and responses.
  always @(posedge clk) begin
    if (mem_WE) we_count <= we_count + 1;
    if (req_valid && req_ready) acc_count <= acc_count + 1;
    if (resp_valid) resp_count <= resp_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat,
                              input int nwe, input logic chk, input int idx,
                              input logic [31:0] val);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_we = nwe;
    v.chk = chk; v.chk_idx = idx; v.chk_val = val;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int k);
    int   g;
    int   lat;
    int   we0;
    bit   got;
    exp_t e;
    @(negedge clk);
    req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      check($sformatf("v%0d_ready", k), 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    we0 = we_count;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (resp_valid) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      check($sformatf("v%0d_resp_timeout", k), 32'(resp_valid), 32'd1);
    end else begin
      check($sformatf("v%0d_rdata", k), resp_rdata, e.rdata);
      check($sformatf("v%0d_err", k), 32'(resp_err), 32'(e.err));
      check($sformatf("v%0d_latency", k), 32'(lat), 32'(e.lat));
    end
    repeat (2) @(negedge clk);
    check($sformatf("v%0d_we_pulses", k), 32'(we_count - we0), 32'(v.exp_we));
    if (v.chk) check($sformatf("v%0d_mem%0d", k, v.chk_idx), mem[v.chk_idx], v.chk_val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int we0;
    int rc0;
    int ac0;
    vecs[0]  = mk(1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'h0000_0005, 1'b0, 2, 0, 1'b0, 0, 32'h0);
    vecs[1]  = mk(1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFF_FFAB, 32'h0,        1'b0, 3, 1, 1'b1, 2, 32'h0000_AB02);
    vecs[2]  = mk(1'b0, 2'b00, 1'b1, 32'h09, 32'h0,        32'hFFFF_FFAB, 1'b0, 2, 0, 1'b0, 0, 32'h0);
    vecs[3]  = mk(1'b0, 2'b00, 1'b0, 32'h09, 32'h0,        32'h0000_00AB, 1'b0, 2, 0, 1'b0, 0, 32'h0);
    vecs[4]  = mk(1'b1, 2'b01, 1'b0, 32'h03, 32'h1234,     32'h0,        1'b1, 1, 0, 1'b1, 0, 32'h0);
    vecs[5]  = mk(1'b1, 2'b01, 1'b0, 32'h0E, 32'h7777_BEEF, 32'h0,        1'b0, 3, 1, 1'b1, 3, 32'hBEEF_0003);
    vecs[6]  = mk(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0,        32'hFFFF_BEEF, 1'b0, 2, 0, 1'b0, 0, 32'h0);
    vecs[7]  = mk(1'b0, 2'b01, 1'b0, 32'h0C, 32'h0,        32'h0000_0003, 1'b0, 2, 0, 1'b0, 0, 32'h0);
    vecs[8]  = mk(1'b1, 2'b10, 1'b0, 32'h18, 32'h1234_5678, 32'h0,        1'b0, 2, 1, 1'b1, 6, 32'h1234_5678);
    vecs[9]  = mk(1'b0, 2'b10, 1'b0, 32'h18, 32'h0,        32'h1234_5678, 1'b0, 2, 0, 1'b0, 0, 32'h0);
    vecs[10] = mk(1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        32'h0,        1'b1, 1, 0, 1'b0, 0, 32'h0);
    vecs[11] = mk(1'b0, 2'b10, 1'b0, 32'h02, 32'h0,        32'h0,        1'b1, 1, 0, 1'b0, 0, 32'h0);
    vecs[12] = mk(1'b0, 2'b00, 1'b1, 32'h1B, 32'h0,        32'h0000_0012, 1'b0, 2, 0, 1'b0, 0, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
    vecs[13] = mk(1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        32'h0,        1'b1, 1, 0, 1'b0, 0, 32'h0);
`else
    vecs[13] = mk(1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        32'h0,        1'b0, 2, 0, 1'b0, 0, 32'h0);
`endif

    rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_A", mem_A, 32'h0);
    check("rst_mem_WD", mem_WD, 32'h0);
    check("rst_mem_WE", 32'(mem_WE), 32'd0);
    check("rst_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b0; mem_clr = 1'b0;
    #1 check("rst_ready_high", 32'(req_ready), 32'd1);

    for (int k = 0; k < 14; k++) run_vec(vecs[k], k);

    // Out-of-range word index: either rejected or driven through as-is.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h80; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
`ifdef LSU_BOUNDS_CHECK_EN
    check("bounds_resp_valid", 32'(resp_valid), 32'd1);
    check("bounds_resp_err", 32'(resp_err), 32'd1);
`else
    check("bounds_mem_A", mem_A, 32'd32);
    @(negedge clk);
    check("bounds_resp_valid", 32'(resp_valid), 32'd1);
    check("bounds_resp_err", 32'(resp_err), 32'd0);
`endif
    repeat (2) @(negedge clk);

    // Reset asserted in the WRITE cycle of a half-store RMW.
    we0 = we_count;
    rc0 = resp_count;
    req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0; req_addr = 32'h10;
    req_wdata = 32'h5555; req_valid = 1'b1;
    check("rmw_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rmw_we_in_write", 32'(mem_WE), 32'd1);
    rst = 1'b1;
    #1 check("rmw_we_gated", 32'(mem_WE), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rmw_ready_after_rst", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("rmw_no_resp", 32'(resp_count - rc0), 32'd0);
    check("rmw_no_we", 32'(we_count - we0), 32'd0);
    check("rmw_mem4", mem[4], 32'h0000_0004);

    // Back-to-back word stores with req_valid held high through the busy period.
    we0 = we_count;
    rc0 = resp_count;
    ac0 = acc_count;
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h1C;
    req_wdata = 32'hA5A5_0001; req_valid = 1'b1;
    check("b2b_ready_first", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_addr = 32'h04; req_wdata = 32'h5A5A_0002;
    @(negedge clk);
    check("b2b_busy_write", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("b2b_busy_resp", 32'(req_ready), 32'd0);
    check("b2b_resp1", 32'(resp_valid), 32'd1);
    @(negedge clk);
    check("b2b_ready_again", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_accepts", 32'(acc_count - ac0), 32'd2);
    check("b2b_we_pulses", 32'(we_count - we0), 32'd2);
    check("b2b_resps", 32'(resp_count - rc0), 32'd2);
    check("b2b_mem7", mem[7], 32'hA5A5_0001);
    check("b2b_mem1", mem[1], 32'h5A5A_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
